// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encoding, reset
// defaults and the queue entry layout.
package fetch_stage_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DROP = 2'd3
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0;
  localparam logic [31:0] NOP_WORD         = 32'h0;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Circular FIFO of fetched {instruction, pc} pairs toward decode.
// A flush empties it in one cycle and overrides any push or pop.
module fetch_queue
  import fetch_stage_pkg::*;
#(
  parameter int  DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             push_i,
  input  fetch_entry_t     push_data_i,
  input  logic             pop_i,
  output fetch_entry_t     head_o,
  output logic             head_valid_o,
  output logic [CNT_W-1:0] count_o
);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  assign do_push = push_i && !flush_i;
  assign do_pop  = pop_i && !flush_i && (count_q != '0);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      // Leaving rd_ptr in place keeps the stale head visible while empty.
      wr_ptr_q <= rd_ptr_q;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // NOTE: storage is reset here only because inst/inst_pc must read zero out
  // of reset; a deep FIFO would normally leave its array unreset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '{inst: NOP_WORD, pc: '0};
    end else if (do_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign head_o       = mem_q[rd_ptr_q];
  assign head_valid_o = (count_q != '0);
  assign count_o      = count_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, single-outstanding imem requester with
// credit-based flow control, redirect handling and the decode-facing queue.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          ADDR_W   = 11,
  parameter int          DEPTH    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic              imem_rvalid,
  input  logic [31:0]       imem_rdata,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [31:0]       inst,
  output logic [31:0]       inst_pc
);

  localparam int               CNT_W   = $clog2(DEPTH + 1);
  localparam logic [CNT_W:0]   DEPTH_C = (CNT_W + 1)'(DEPTH);

  fetch_state_e     state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      req_pc_q, req_pc_d;
  logic [CNT_W-1:0] q_count;
  logic [CNT_W:0]   occ_after_pop;
  logic             push;
  logic             pop;
  fetch_entry_t     push_entry;
  fetch_entry_t     head;

  assign pop           = inst_valid && inst_ready;
  assign occ_after_pop = {1'b0, q_count} - (CNT_W + 1)'(pop);

  // NOTE: every always_comb output gets a default before the case so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    push     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          state_d = ST_REQ;
        end else if ({1'b0, q_count} < DEPTH_C) begin
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          state_d = imem_ack ? ST_DROP : ST_REQ;
        end else if (imem_ack) begin
          req_pc_d = pc_q;
          pc_d     = pc_q + 32'd1;
          state_d  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          state_d = imem_rvalid ? ST_REQ : ST_DROP;
        end else if (imem_rvalid) begin
          push    = 1'b1;
          state_d = (occ_after_pop + 1'b1 < DEPTH_C) ? ST_REQ : ST_IDLE;
        end
      end
      ST_DROP: begin
        // A redirect coinciding with the wrong-path return must not strand the
        // FSM waiting for data that has already arrived.
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          state_d = imem_rvalid ? ST_REQ : ST_DROP;
        end else if (imem_rvalid) begin
          state_d = (occ_after_pop < DEPTH_C) ? ST_REQ : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      pc_q     <= RESET_PC;
      req_pc_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
    end
  end

  assign imem_req   = (state_q == ST_REQ);
  assign imem_addr  = pc_q[ADDR_W-1:0];
  assign push_entry = '{inst: imem_rdata, pc: req_pc_q};

  fetch_queue #(
    .DEPTH(DEPTH)
  ) u_queue (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (redirect_valid),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .head_o      (head),
    .head_valid_o(inst_valid),
    .count_o     (q_count)
  );

  assign inst    = head.inst;
  assign inst_pc = head.pc;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a memory responder with configurable
// latency and an architectural model of the expected in-order instruction stream.
module tb_fetch_stage;

  localparam int          ADDR_W   = 11;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              redirect_valid;
  logic [31:0]       redirect_pc;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic              imem_rvalid;
  logic [31:0]       imem_rdata;
  logic              inst_valid;
  logic              inst_ready;
  logic [31:0]       inst;
  logic [31:0]       inst_pc;

  fetch_stage #(.RESET_PC(RESET_PC), .ADDR_W(ADDR_W), .DEPTH(2)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .inst          (inst),
    .inst_pc       (inst_pc)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [ADDR_W-1:0] a);
    return 32'h5EED_0000 ^ (32'(a) * 32'h0001_9E37) ^ 32'(a);
  endfunction

  // Memory responder: acks a held request after a delay, returns data later.
  bit                zero_wait = 1'b1;
  int                max_delay = 0;
  bit                hold      = 1'b0;
  logic [ADDR_W-1:0] hold_addr = '0;
  bit                pend      = 1'b0;
  logic [ADDR_W-1:0] pend_addr = '0;
  int                rv_cnt    = 0;
  int                ack_cnt   = -1;

  initial begin
    imem_ack    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    forever begin
      @(negedge clk);
      imem_ack    = 1'b0;
      imem_rvalid = 1'b0;
      if (pend) begin
        if (!(hold && pend_addr == hold_addr)) begin
          if (rv_cnt == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(pend_addr);
            pend        = 1'b0;
          end else begin
            rv_cnt--;
          end
        end
      end else if (imem_req) begin
        if (ack_cnt < 0) ack_cnt = zero_wait ? 0 : int'($urandom_range(max_delay, 0));
        if (ack_cnt == 0) begin
          imem_ack  = 1'b1;
          pend      = 1'b1;
          pend_addr = imem_addr;
          rv_cnt    = zero_wait ? 0 : int'($urandom_range(max_delay, 0));
          ack_cnt   = -1;
        end else begin
          ack_cnt--;
        end
      end
    end
  end

  // Request must stay up with a stable address until acked, unless redirected.
  bit                p_req   = 1'b0;
  bit                p_ack   = 1'b0;
  bit                p_redir = 1'b0;
  logic [ADDR_W-1:0] p_addr  = '0;

  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (rst_n && p_req && !p_ack && !p_redir)
        check("req_stable", {imem_req, imem_addr}, {1'b1, p_addr});
      p_req   = rst_n && imem_req;
      p_ack   = imem_ack;
      p_redir = redirect_valid;
      p_addr  = imem_addr;
    end
  end

  // Architectural model: consumed words follow pc, pc+1, ... restarting at
  // each redirect target; a pop coinciding with a redirect does not happen.
  logic [31:0] exp_pc    = RESET_PC;
  int          n_pop     = 0;
  bit          chk_empty = 1'b0;

  task automatic cycle(input bit rdy, input bit redir, input logic [31:0] tgt);
    @(negedge clk);
    if (chk_empty) begin
      check("flush_empty", inst_valid, 1'b0);
      chk_empty = 1'b0;
    end
    inst_ready     = rdy;
    redirect_valid = redir;
    redirect_pc    = tgt;
    if (redir) begin
      exp_pc    = tgt;
      chk_empty = 1'b1;
    end else if (inst_valid && rdy) begin
      check("inst_pc", inst_pc, exp_pc);
      check("inst_word", inst, mem_word(exp_pc[ADDR_W-1:0]));
      exp_pc = exp_pc + 32'd1;
      n_pop++;
    end
  endtask

  task automatic run_until_pops(input int n, input int budget, input string tag);
    int c = 0;
    while (n_pop < n && c < budget) begin
      cycle(1'b1, 1'b0, '0);
      c++;
    end
    check(tag, 64'(n_pop >= n), 64'd1);
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    @(posedge clk);
    pend    = 1'b0;
    ack_cnt = -1;
    hold    = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_outputs", {imem_req, inst_valid, inst, inst_pc}, '0);
    exp_pc    = RESET_PC;
    n_pop     = 0;
    chk_empty = 1'b0;
    rst_n     = 1'b1;
    check("rst_no_req", imem_req, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n          = 1'b0;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;

    // 1: zero-wait memory, always ready -> one instruction every two cycles.
    zero_wait = 1'b1;
    do_reset();
    cycle(1'b1, 1'b0, '0);
    check("t1_first_req", {imem_req, imem_addr}, {1'b1, RESET_PC[ADDR_W-1:0]});
    repeat (19) cycle(1'b1, 1'b0, '0);
    check("t1_rate", n_pop, 9);

    // 2: decode stalled -> two words queued, fetch stops; drain and resume.
    do_reset();
    repeat (10) cycle(1'b0, 1'b0, '0);
    check("t2_full", {imem_req, inst_valid, inst_pc}, {1'b0, 1'b1, 32'd0});
    repeat (2) cycle(1'b1, 1'b0, '0);
    cycle(1'b0, 1'b0, '0);
    check("t2_drained", {inst_valid, 32'(n_pop)}, {1'b0, 32'd2});
    run_until_pops(4, 20, "t2_resume");

    // 3: redirect while waiting on the word for pc 5.
    do_reset();
    hold      = 1'b1;
    hold_addr = ADDR_W'(5);
    run_until_pops(5, 40, "t3_pre");
    repeat (3) cycle(1'b1, 1'b0, '0);
    check("t3_waiting", {imem_req, inst_valid}, 2'b00);
    cycle(1'b1, 1'b1, 32'h40);
    @(posedge clk);
    hold = 1'b0;
    run_until_pops(n_pop + 3, 40, "t3_post");

    // 4: redirect, rvalid and pop in the same cycle with a word queued.
    do_reset();
    hold      = 1'b1;
    hold_addr = ADDR_W'(1);
    repeat (6) cycle(1'b0, 1'b0, '0);
    check("t4_pre", {imem_req, inst_valid, inst_pc}, {1'b0, 1'b1, 32'd0});
    @(posedge clk);
    hold = 1'b0;
    cycle(1'b1, 1'b1, 32'h0000_0123);
    cycle(1'b1, 1'b0, '0);
    check("t4_req", {imem_req, imem_addr}, {1'b1, 11'h123});
    run_until_pops(n_pop + 2, 30, "t4_post");

    // 5: random memory latency, decode backpressure and redirects.
    do_reset();
    zero_wait = 1'b0;
    max_delay = 5;
    for (int i = 0; i < 3000; i++) begin
      bit          rdy;
      bit          rd;
      logic [31:0] tgt;
      rdy = ($urandom_range(99, 0) < 70);
      rd  = ($urandom_range(99, 0) < 4);
      tgt = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15, 0)))
                                        : 32'($urandom());
      cycle(rdy, rd, tgt);
    end
    check("t5_progress", 64'(n_pop > 100), 64'd1);

    // 6: reset mid-transaction, stray rvalid afterwards must be ignored.
    zero_wait = 1'b1;
    do_reset();
    hold      = 1'b1;
    hold_addr = ADDR_W'(3);
    run_until_pops(3, 40, "t6_pre");
    repeat (2) cycle(1'b1, 1'b0, '0);
    rst_n      = 1'b0;
    inst_ready = 1'b0;
    @(negedge clk);
    check("t6_in_reset", {imem_req, inst_valid}, 2'b00);
    @(negedge clk);
    exp_pc    = RESET_PC;
    n_pop     = 0;
    chk_empty = 1'b0;
    rst_n     = 1'b1;
    @(posedge clk);
    hold = 1'b0;
    cycle(1'b0, 1'b0, '0);
    check("t6_restart", {imem_req, imem_addr, inst_valid}, {1'b1, RESET_PC[ADDR_W-1:0], 1'b0});
    cycle(1'b0, 1'b0, '0);
    check("t6_stray", inst_valid, 1'b0);
    run_until_pops(4, 30, "t6_post");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
